robotron_audio_out: RTL and testbench
=====================================

Name: robotron_audio_out

Overview:
- Downstream output stage for robotron_sound.
- Consumes the 8-bit offset-binary DAC_OUT sample from the sound board.
- Produces two outputs:
  - A smoothed, attenuated, signed 16-bit PCM stream with a valid strobe, for I2S/HDMI consumers.
  - A 1-bit first-order sigma-delta PDM bitstream for a single FPGA audio pin.
- Runs in the clk_fast domain, so no clock crossing is needed.

Parameters:
- CE_DIV, 4: clk_fast cycles per filter/PCM update tick (2..256).
- K, 4: IIR low-pass shift; the pole is 1 - 2^-K (1..8).

Ports:
- clk_fast    in   1   system clock; same clock as robotron_sound clk_fast.
- reset       in   1   synchronous, active-high reset.
- dac_in      in   8   offset-binary sample from robotron_sound DAC_OUT; 0x80 = midscale.
- mute        in   1   1 = filter target forced to 0 (declick fade, no hard cut).
- atten       in   3   arithmetic right shift applied to filtered output (0 = full scale).
- pcm_out     out  16  signed two's-complement filtered sample.
- pcm_valid   out  1   one-cycle strobe; high in the cycle pcm_out takes a new value.
- pdm_out     out  1   first-order sigma-delta bitstream.

Behaviour:
- Clock and reset: one clock, clk_fast. reset is synchronous and active-high.
- Reset values:
  - tick counter = 0, filter accumulator acc = 0, sd_acc = 0.
  - pcm_out = 0x0000, pcm_valid = 0, pdm_out = 0.
  - A reset asserted mid-operation clears all state on the next edge; there is no partial fade.
- Tick generator:
  - cnt counts 0..CE_DIV-1 and wraps.
  - tick = (cnt == CE_DIV-1). The first tick after reset release occurs CE_DIV cycles later.
- Input conversion (combinational):
  - x = {~dac_in[7], dac_in[6:0], 8'h00}, signed 16 bits. So 0xFF→0x7F00, 0x80→0x0000, 0x00→0x8000.
  - If mute = 1, x = 0.
- IIR low-pass on tick:
  - acc is signed, 16+K bits.
  - acc_next = acc + sext(x) − (acc >>> K), with arithmetic shift.
  - Equilibrium is acc >>> K == x exactly. Truncation must not leave a steady-state offset.
  - acc holds its value between ticks.
- PCM output:
  - On a tick cycle, register pcm_out <= (acc_next >>> K) >>> atten and pcm_valid <= 1.
  - On all other cycles pcm_valid <= 0 and pcm_out holds.
  - Latency: dac_in sampled at tick edge N appears on pcm_out at edge N.
  - atten is sampled at the tick only.
- Sigma-delta, every clk_fast cycle:
  - u = pcm_out ^ 16'h8000 (unsigned).
  - s = {1'b0, sd_acc} + u, 17 bits.
  - sd_acc <= s[15:0], pdm_out <= s[16].
  - Mean pdm density = u / 65536. u = 0 gives constant 0; u = 0x8000 gives the pattern 0,1,0,1.
- Simultaneous events: mute and atten changes on a tick cycle take effect in that same tick. dac_in changes between ticks are ignored.
- Width rules: no saturation is needed. |x| ≤ 0x8000 and the filter is non-overshooting, so acc never wraps.

Decomposition:
- Shared package robotron_audio_pkg:
  - DAC_W = 8, PCM_W = 16.
  - MIDSCALE = 8'h80.
  - A function for offset-binary to signed conversion.
- Sub-module robotron_sigma_delta (PCM_W-bit first-order modulator), reused by future output pins.
- Tick generator, IIR and attenuator stay in the top block.

Test Plan:
1. Reset held 10 cycles, dac_in = 0x80 → pcm_out = 0x0000, pcm_valid pulses every 4th cycle, pdm_out alternates 0,1 from the cycle after release.
2. From reset, dac_in = 0xFF → first pcm_valid gives pcm_out = 0x07F0, values rise monotonically, pcm_out = 0x7F00 exactly within 300 ticks, pdm density ≈ 0.996.
3. dac_in = 0x00 → settles to pcm_out = 0x8000, then pdm_out constant 0 after settling.
4. Settled at 0x7F00, atten = 2 → next tick pcm_out = 0x1FC0; atten = 7 → 0x00FE.
5. Settled at 0x7F00, mute = 1 → first tick pcm_out = 0x7710, monotonic decay to 0x0000; mute = 0 → climbs back to 0x7F00.
6. Reset asserted mid-decay (pcm_out ≠ 0) → next edge: pcm_out = 0, pcm_valid = 0, pdm_out = 0, cnt = 0; next valid strobe exactly CE_DIV cycles after release.

Source files
------------

// File: rtl/robotron_audio_pkg.sv
// robotron_audio_pkg
// Shared widths, constants and the sample-format conversion used by the
// robotron audio output stage and its sub-modules.
package robotron_audio_pkg;

    localparam int DAC_W = 8;
    localparam int PCM_W = 16;

    localparam logic [DAC_W-1:0] MIDSCALE = 8'h80;

    // Offset-binary DAC code to signed PCM: flipping the MSB recentres the
    // code on zero, and the low byte of padding scales it to full PCM range.
    // 0xFF -> 0x7F00, 0x80 -> 0x0000, 0x00 -> 0x8000.
    function automatic logic signed [PCM_W-1:0] dac_to_pcm(input logic [DAC_W-1:0] code);
        return {~code[DAC_W-1], code[DAC_W-2:0], 8'h00};
    endfunction

endpackage

// File: rtl/robotron_audio_if.sv
// robotron_audio_if
// Groups the sample input, control and audio output signals of the
// robotron audio output stage.
//   dac_in    : offset-binary sample from the sound board (0x80 = midscale)
//   mute      : 1 = fade the filter towards silence
//   atten     : arithmetic right shift applied to the filtered sample
//   pcm_out   : signed filtered PCM sample
//   pcm_valid : one-cycle strobe marking a new pcm_out value
//   pdm_out   : first-order sigma-delta bitstream
// master = the side that supplies samples/controls and consumes audio,
// slave  = the output stage itself.
interface robotron_audio_if;
    import robotron_audio_pkg::*;

    logic        [DAC_W-1:0] dac_in;
    logic                    mute;
    logic        [2:0]       atten;
    logic signed [PCM_W-1:0] pcm_out;
    logic                    pcm_valid;
    logic                    pdm_out;

    modport master (
        output dac_in,
        output mute,
        output atten,
        input  pcm_out,
        input  pcm_valid,
        input  pdm_out
    );

    modport slave (
        input  dac_in,
        input  mute,
        input  atten,
        output pcm_out,
        output pcm_valid,
        output pdm_out
    );

endinterface

// File: rtl/robotron_sigma_delta.sv
// robotron_sigma_delta
// First-order sigma-delta modulator turning a signed W-bit PCM sample into a
// 1-bit density stream (mean density = (pcm ^ MSB) / 2^W).
// Ports:
//   clk     : clock, one modulator step per cycle
//   reset   : synchronous, active-high
//   pcm     : signed two's-complement input sample
//   pdm_out : registered bitstream (carry out of the accumulator)
module robotron_sigma_delta #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] pcm,
    output logic         pdm_out
);

    logic [W-1:0] u_s;
    logic [W:0]   sum_s;
    logic [W-1:0] sd_acc_r;
    logic         pdm_r;

    // Offset the signed sample to unsigned and add it to the error accumulator.
    always_comb begin
        u_s   = pcm ^ {1'b1, {(W-1){1'b0}}};
        sum_s = {1'b0, sd_acc_r} + {1'b0, u_s};
    end

    // Keep the residue, emit the carry as the output bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sd_acc_r <= '0;
            pdm_r    <= 1'b0;
        end else begin
            sd_acc_r <= sum_s[W-1:0];
            pdm_r    <= sum_s[W];
        end
    end

    assign pdm_out = pdm_r;

endmodule

// File: rtl/robotron_audio_out.sv
// robotron_audio_out
// Output stage for the robotron sound board. Converts the 8-bit offset-binary
// DAC sample into a smoothed, attenuated signed 16-bit PCM stream and a 1-bit
// sigma-delta PDM stream.
// Ports:
//   clk_fast : system clock (same as the sound board)
//   reset    : synchronous, active-high
//   aud      : robotron_audio_if.slave (dac_in, mute, atten in;
//              pcm_out, pcm_valid, pdm_out out)
// Parameters:
//   CE_DIV : clk_fast cycles per filter/PCM update tick (2..256)
//   K      : IIR shift; pole at 1 - 2^-K (1..8)
module robotron_audio_out
    import robotron_audio_pkg::*;
#(
    parameter int CE_DIV = 4,
    parameter int K      = 4
) (
    input  logic             clk_fast,
    input  logic             reset,
    robotron_audio_if.slave  aud
);

    localparam int CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int ACC_W = PCM_W + K;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CE_DIV - 1);

    logic        [CNT_W-1:0] cnt_r;
    logic                    tick_s;
    logic signed [PCM_W-1:0] x_s;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [PCM_W-1:0] filt_s;
    logic signed [PCM_W-1:0] att_s;
    logic signed [PCM_W-1:0] pcm_r;
    logic                    pcm_valid_r;
    logic                    pdm_s;

    assign tick_s = (cnt_r == CNT_LAST);

    // Tick divider: counts 0..CE_DIV-1 and wraps on the tick cycle.
    always_ff @(posedge clk_fast) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Filter target and next filter state. The accumulator holds the output
    // scaled by 2^K, so its equilibrium is acc >>> K == x with no truncation
    // offset; the fraction bits only hold the sub-LSB part of the approach.
    always_comb begin
        if (aud.mute) begin
            x_s = '0;
        end else begin
            x_s = dac_to_pcm(aud.dac_in);
        end
        acc_next_s = acc_r + ACC_W'(x_s) - (acc_r >>> K);
        filt_s     = PCM_W'(acc_next_s >>> K);
        att_s      = filt_s >>> aud.atten;
    end

    // IIR accumulator: updated on ticks only, held otherwise.
    always_ff @(posedge clk_fast) begin
        if (reset) begin
            acc_r <= '0;
        end else if (tick_s) begin
            acc_r <= acc_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // PCM output register and its one-cycle valid strobe.
    always_ff @(posedge clk_fast) begin
        if (reset) begin
            pcm_r       <= '0;
            pcm_valid_r <= 1'b0;
        end else if (tick_s) begin
            pcm_r       <= att_s;
            pcm_valid_r <= 1'b1;
        end else begin
            pcm_r       <= pcm_r;
            pcm_valid_r <= 1'b0;
        end
    end

    robotron_sigma_delta #(
        .W (PCM_W)
    ) u_sigma_delta (
        .clk     (clk_fast),
        .reset   (reset),
        .pcm     (pcm_r),
        .pdm_out (pdm_s)
    );

    assign aud.pcm_out   = pcm_r;
    assign aud.pcm_valid = pcm_valid_r;
    assign aud.pdm_out   = pdm_s;

endmodule

// File: tb/tb_robotron_audio_out.sv
// tb_robotron_audio_out
// Directed bench for robotron_audio_out (CE_DIV = 4, K = 4). Inputs are driven
// and outputs sampled on the falling edge of clk_fast.
module tb_robotron_audio_out;
    import robotron_audio_pkg::*;

    logic clk_fast = 1'b0;
    logic reset    = 1'b1;

    always #5 clk_fast = ~clk_fast;

    robotron_audio_if aud ();

    robotron_audio_out #(
        .CE_DIV (4),
        .K      (4)
    ) dut (
        .clk_fast (clk_fast),
        .reset    (reset),
        .aud      (aud)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_fast);
    endtask

    // Advance to the next cycle showing pcm_valid, bounded.
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        step();
        while (aud.pcm_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        if (aud.pcm_valid !== 1'b1) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic signed [15:0] cur;
    logic signed [15:0] prev;
    logic               reached;
    int                 ones;
    int                 first_valid;

    initial begin
        aud.dac_in = 8'h80;
        aud.mute   = 1'b0;
        aud.atten  = 3'd0;
        reset      = 1'b1;

        // 1: reset state, midscale idle
        repeat (10) step();
        check_val("rst_pcm",   32'(aud.pcm_out),   32'h0000);
        check_val("rst_valid", 32'(aud.pcm_valid), 32'd0);
        check_val("rst_pdm",   32'(aud.pdm_out),   32'd0);
        reset = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step();
            check_val("mid_valid", 32'(aud.pcm_valid), ((cyc % 4) == 0) ? 32'd1 : 32'd0);
            check_val("mid_pdm",   32'(aud.pdm_out),   ((cyc % 2) == 0) ? 32'd1 : 32'd0);
            check_val("mid_pcm",   32'(aud.pcm_out),   32'h0000);
        end

        // 2: full-scale positive step from reset
        reset      = 1'b1;
        aud.dac_in = 8'hFF;
        step();
        step();
        reset = 1'b0;
        wait_tick("pos_first");
        check_val("pos_first", 32'(aud.pcm_out), 32'h07F0);
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            prev = aud.pcm_out;
            wait_tick("pos_rise");
            cur = aud.pcm_out;
            check_val("pos_rise", 32'(cur >= prev), 32'd1);
            if (cur == 16'sh7F00) reached = 1'b1;
        end
        check_val("pos_settle", 32'(reached), 32'd1);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (aud.pdm_out) ones++;
        end
        check_val("pos_density", 32'(ones), 32'd255);

        // 4: attenuation sampled at the tick
        aud.atten = 3'd2;
        wait_tick("att2");
        check_val("att2", 32'(aud.pcm_out), 32'h1FC0);
        aud.atten = 3'd7;
        wait_tick("att7");
        check_val("att7", 32'(aud.pcm_out), 32'h00FE);
        aud.atten = 3'd0;
        wait_tick("att0");
        check_val("att0", 32'(aud.pcm_out), 32'h7F00);

        // 5: mute fade-out and recovery
        aud.mute = 1'b1;
        wait_tick("mute_first");
        check_val("mute_first", 32'(aud.pcm_out), 32'h7710);
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            prev = aud.pcm_out;
            wait_tick("mute_decay");
            cur = aud.pcm_out;
            check_val("mute_decay", 32'(cur <= prev), 32'd1);
            if (cur == 16'sh0000) reached = 1'b1;
        end
        check_val("mute_zero", 32'(reached), 32'd1);
        aud.mute = 1'b0;
        reached  = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            prev = aud.pcm_out;
            wait_tick("unmute_rise");
            cur = aud.pcm_out;
            check_val("unmute_rise", 32'(cur >= prev), 32'd1);
            if (cur == 16'sh7F00) reached = 1'b1;
        end
        check_val("unmute_settle", 32'(reached), 32'd1);

        // 6: reset in the middle of a fade
        aud.mute = 1'b1;
        wait_tick("mid_fade");
        wait_tick("mid_fade");
        wait_tick("mid_fade");
        check_val("fade_nonzero", 32'(aud.pcm_out != 16'sh0000), 32'd1);
        reset = 1'b1;
        step();
        check_val("fade_rst_pcm",   32'(aud.pcm_out),   32'h0000);
        check_val("fade_rst_valid", 32'(aud.pcm_valid), 32'd0);
        check_val("fade_rst_pdm",   32'(aud.pdm_out),   32'd0);
        step();
        reset       = 1'b0;
        aud.mute    = 1'b0;
        first_valid = 0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (aud.pcm_valid === 1'b1 && first_valid == 0) first_valid = n;
        end
        check_val("fade_rst_first_tick", 32'(first_valid), 32'd4);

        // 3: full-scale negative, PDM goes silent
        aud.dac_in = 8'h00;
        reached    = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            wait_tick("neg_fall");
            if (aud.pcm_out == 16'sh8000) reached = 1'b1;
        end
        check_val("neg_settle", 32'(reached), 32'd1);
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (aud.pdm_out) ones++;
        end
        check_val("neg_pdm_zero", 32'(ones), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
